// File: rtl/pll_reset_seq.sv
// pll_reset_seq
//   Power-up / recovery sequencer for a board PLL on the refclk domain. It
//   pulses the PLL reset, waits for lock, and requires a run of consecutive
//   locked cycles before it releases the system reset. If lock does not arrive
//   in time, it pulses the PLL reset again. It counts those retries and any
//   lock losses seen while running.
//
// Parameters
//   PLL_RST_CYCLES     PLL reset pulse width in refclk cycles (2..255)
//   LOCK_STABLE_CYCLES consecutive locked cycles before release (2..65535)
//   LOCK_TIMEOUT       cycles allowed in WAIT_LOCK before a retry (4..65535)
//   SYNC_STAGES        depth of the locked synchronizer (2..4)
//
// Ports
//   refclk     in   free-running board clock, the only clock
//   rst_n      in   asynchronous active-low reset
//   locked     in   PLL lock, asynchronous to refclk
//   soft_rst   in   synchronous request to restart the whole sequence
//   pll_rst    out  active-high reset to the PLL
//   sys_rst_n  out  active-low reset for downstream logic
//   ready      out  high only while running
//   retry_cnt  out  saturating count of lock-timeout retries
//   loss_cnt   out  saturating count of lock losses while running
module pll_reset_seq #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT       = 65535,
  parameter int unsigned SYNC_STAGES        = 2
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       soft_rst,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int unsigned PW = $clog2(PLL_RST_CYCLES + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [PW-1:0] PLL_LAST = PW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;

  logic [PW-1:0] pll_cnt_q, pll_cnt_d;
  logic [TW-1:0] to_cnt_q,  to_cnt_d;
  logic [SW-1:0] stb_cnt_q, stb_cnt_d;
  logic [3:0]    retry_q,   retry_d;
  logic [7:0]    loss_q,    loss_d;

  logic pll_rst_q,   pll_rst_d;
  logic sys_rst_n_q, sys_rst_n_d;
  logic ready_q,     ready_d;

  // Lock synchronizer; only the last stage feeds any decision.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], locked};
  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    pll_cnt_d = '0;
    to_cnt_d  = '0;
    stb_cnt_d = '0;
    retry_d   = retry_q;
    loss_d    = loss_q;

    // Each counter is only live in its own state. Defaulting it to zero
    // clears it on every exit path.
    unique case (state_q)
      ST_PLL_RST: begin
        if (pll_cnt_q == PLL_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          pll_cnt_d = pll_cnt_q + PW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_PLL_RST;
          retry_d = (retry_q == '1) ? retry_q : retry_q + 4'd1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (stb_cnt_q == STB_LAST) begin
          state_d = ST_RUN;
        end else begin
          stb_cnt_d = stb_cnt_q + SW'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          loss_d  = (loss_q == '1) ? loss_q : loss_q + 8'd1;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase

    // soft_rst overrides the transition but keeps any loss recorded above
    // on the same edge.
    if (soft_rst) begin
      state_d   = ST_PLL_RST;
      pll_cnt_d = '0;
      to_cnt_d  = '0;
      stb_cnt_d = '0;
    end

    // Outputs are decoded from the next state so the flops line up with it.
    pll_rst_d   = (state_d == ST_PLL_RST);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RST;
      sync_q      <= '0;
      pll_cnt_q   <= '0;
      to_cnt_q    <= '0;
      stb_cnt_q   <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      pll_cnt_q   <= pll_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule
